ball_sequencer: RTL and testbench

- Game-flow controller for the ball datapath.
- Sequences serve, play, miss, game-over and win phases.
- Drives the ball block's synchronous reset (`ball_rst`) and a per-step movement enable (`move_en`).
- Tracks remaining lives and flags end of game (`game_over`, `win`) to the ball, paddle, brick and display logic.

---
 rtl/ball_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_ball_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ball_sequencer.sv
// rtl/ball_sequencer.sv - game-flow FSM driving ball reset, step enable, lives and end-of-game flags
// Optional macro BALL_SPEEDUP_EN: every 8th brick hit shortens the movement step interval.

module ball_sequencer #(
   parameter int LIVES        = 3,
   parameter int SERVE_FRAMES = 90,
   parameter int MISS_FRAMES  = 60,
   parameter int MISS_Y       = 472,
   parameter int STEP_DIV     = 250000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       frame_tick,
   input  logic [8:0] ball_y,
   input  logic [5:0] bricks_left,
   input  logic       brick_hit,
   output logic       ball_rst,
   output logic       move_en,
   output logic [2:0] lives,
   output logic       game_over,
   output logic       win,
   output logic [2:0] state
);

   localparam int SW = $clog2(STEP_DIV);

   localparam logic [7:0]    SERVE_LAST = 8'(SERVE_FRAMES - 1);
   localparam logic [7:0]    MISS_LAST  = 8'(MISS_FRAMES - 1);
   localparam logic [8:0]    MISS_Y_V   = 9'(MISS_Y);
   localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV - 1);
   localparam logic [2:0]    LIVES_V    = 3'(LIVES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_MISS  = 3'd3,
      S_OVER  = 3'd4,
      S_WIN   = 3'd5
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [7:0]    r_frame;
   logic [SW-1:0] r_step;
   logic [2:0]    r_lives;
   logic          r_ball_rst;
   logic          r_move_en;
   logic          r_game_over;
   logic          r_win;

   logic          w_frame_clr;
   logic          w_frame_inc;
   logic          w_step_clr;
   logic          w_lives_dec;
   logic          w_new_game;
   logic [SW-1:0] w_div_last;
   logic          w_step_wrap;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_frame_clr = 1'b0;
      w_frame_inc = 1'b0;
      w_step_clr  = 1'b0;
      w_lives_dec = 1'b0;
      w_new_game  = 1'b0;
      case (r_state)
         S_IDLE, S_OVER, S_WIN: begin
            if (start) begin
               w_next      = S_SERVE;
               w_frame_clr = 1'b1;
               w_new_game  = 1'b1;
            end
         end
         S_SERVE: begin
            if (frame_tick) begin
               if (r_frame == SERVE_LAST) begin
                  w_next     = S_PLAY;
                  w_step_clr = 1'b1;
               end else begin
                  w_frame_inc = 1'b1;
               end
            end
         end
         S_PLAY: begin
            // Clearing the wall wins even if the ball is lost in the same cycle.
            if (bricks_left == 6'd0) begin
               w_next = S_WIN;
            end else if (ball_y >= MISS_Y_V) begin
               w_next      = S_MISS;
               w_frame_clr = 1'b1;
               w_lives_dec = 1'b1;
            end
         end
         S_MISS: begin
            if (frame_tick) begin
               if (r_frame == MISS_LAST) begin
                  w_frame_clr = 1'b1;
                  w_next      = (r_lives == 3'd0) ? S_OVER : S_SERVE;
               end else begin
                  w_frame_inc = 1'b1;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_step_wrap = (r_state == S_PLAY) && (r_step == w_div_last);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_frame     <= 8'd0;
         r_step      <= '0;
         r_lives     <= LIVES_V;
         r_ball_rst  <= 1'b1;
         r_move_en   <= 1'b0;
         r_game_over <= 1'b0;
         r_win       <= 1'b0;
      end else begin
         if (w_frame_clr)      r_frame <= 8'd0;
         else if (w_frame_inc) r_frame <= r_frame + 8'd1;

         if (w_step_clr || w_step_wrap) r_step <= '0;
         else if (r_state == S_PLAY)    r_step <= r_step + 1'b1;

         if (w_new_game)                          r_lives <= LIVES_V;
         else if (w_lives_dec && r_lives != 3'd0) r_lives <= r_lives - 3'd1;

         // Ball stays frozen (not reset) during MISS so the loss point remains visible.
         r_ball_rst  <= !((w_next == S_PLAY) || (w_next == S_MISS));
         r_move_en   <= w_step_wrap && (w_next == S_PLAY);
         r_game_over <= (w_next == S_OVER);
         r_win       <= (w_next == S_WIN);
      end
   end

`ifdef BALL_SPEEDUP_EN
   localparam logic [SW-1:0] DIV_DEC   = SW'(STEP_DIV / 8);
   localparam logic [SW-1:0] DIV_FLOOR = SW'((STEP_DIV / 4 > 0) ? (STEP_DIV / 4 - 1) : 0);

   logic [3:0]    r_hits;
   logic [SW-1:0] r_div_tgt;
   logic [SW-1:0] r_div_act;
   logic [SW-1:0] w_div_reduced;

   assign w_div_reduced = ((r_div_tgt - DIV_FLOOR) >= DIV_DEC) ? (r_div_tgt - DIV_DEC) : DIV_FLOOR;

   always_ff @(posedge clk) begin
      if (reset || w_new_game) begin
         r_hits    <= 4'd0;
         r_div_tgt <= STEP_LAST;
         r_div_act <= STEP_LAST;
      end else begin
         if (r_state == S_PLAY && brick_hit) begin
            r_hits <= r_hits + 4'd1;
            if (r_hits[2:0] == 3'd7) r_div_tgt <= w_div_reduced;
         end
         // A new divisor only lands on an interval boundary, never mid-interval.
         if (w_step_clr || w_step_wrap) r_div_act <= r_div_tgt;
      end
   end

   assign w_div_last = r_div_act;
`else
   logic w_unused_hit;
   assign w_unused_hit = brick_hit;
   assign w_div_last   = STEP_LAST;
`endif

   assign ball_rst  = r_ball_rst;
   assign move_en   = r_move_en;
   assign lives     = r_lives;
   assign game_over = r_game_over;
   assign win       = r_win;
   assign state     = r_state;

endmodule

// File: tb/tb_ball_sequencer.sv
// tb/tb_ball_sequencer.sv - randomized self-checking bench for ball_sequencer
// Expectations come from game rules: frame counts, step period arithmetic and a lives tally.

module tb_ball_sequencer;

   localparam int LIVES        = 3;
   localparam int SERVE_FRAMES = 3;
   localparam int MISS_FRAMES  = 2;
   localparam int MISS_Y       = 472;
   localparam int STEP_DIV     = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       frame_tick;
   logic [8:0] ball_y;
   logic [5:0] bricks_left;
   logic       brick_hit;
   logic       ball_rst;
   logic       move_en;
   logic [2:0] lives;
   logic       game_over;
   logic       win;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;
   int exp_lives;

   always #5 clk = ~clk;

   ball_sequencer #(
      .LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES), .MISS_FRAMES(MISS_FRAMES),
      .MISS_Y(MISS_Y), .STEP_DIV(STEP_DIV)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
      .ball_y(ball_y), .bricks_left(bricks_left), .brick_hit(brick_hit),
      .ball_rst(ball_rst), .move_en(move_en), .lives(lives),
      .game_over(game_over), .win(win), .state(state)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic safe_inputs();
      ball_y      = 9'($urandom_range(0, MISS_Y - 1));
      bricks_left = 6'($urandom_range(1, 63));
   endtask

   task automatic pulse_frame();
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
   endtask

   // From SERVE just entered: PLAY follows the edge of the SERVE_FRAMES-th tick.
   task automatic serve_to_play(input bit hold_start);
      for (int i = 0; i < SERVE_FRAMES; i++) begin
         int gap = $urandom_range(0, 4);
         for (int g = 0; g < gap; g++) begin
            start = hold_start;
            tick();
            checks++; if (state !== 3'd1) begin errors++; $display("FAIL serve_wait state got %0d want 1", state); end
            checks++; if (ball_rst !== 1'b1) begin errors++; $display("FAIL serve_wait ball_rst got %0b want 1", ball_rst); end
         end
         start = hold_start;
         pulse_frame();
         if (i == SERVE_FRAMES - 1) begin
            checks++; if (state !== 3'd2) begin errors++; $display("FAIL serve_release state got %0d want 2", state); end
            checks++; if (ball_rst !== 1'b0) begin errors++; $display("FAIL serve_release ball_rst got %0b want 0", ball_rst); end
         end else begin
            checks++; if (state !== 3'd1) begin errors++; $display("FAIL serve_count state got %0d want 1", state); end
         end
      end
      start = 1'b0;
   endtask

   // From PLAY just entered: move_en is high after every STEP_DIV-th edge.
   task automatic run_play(input int n);
      for (int k = 1; k <= n; k++) begin
         frame_tick = ($urandom_range(0, 2) == 0);
         brick_hit  = ($urandom_range(0, 3) == 0);
         safe_inputs();
         tick();
         checks++; if (move_en !== ((k % STEP_DIV) == 0)) begin errors++; $display("FAIL play_move_en k=%0d got %0b want %0b", k, move_en, (k % STEP_DIV) == 0); end
         checks++; if (state !== 3'd2) begin errors++; $display("FAIL play_state k=%0d got %0d want 2", k, state); end
      end
      frame_tick = 1'b0;
      brick_hit  = 1'b0;
   endtask

   task automatic do_miss(input bit start_on_exit);
      ball_y      = 9'($urandom_range(MISS_Y, 511));
      bricks_left = 6'($urandom_range(1, 63));
      tick();
      exp_lives--;
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL miss_enter state got %0d want 3", state); end
      checks++; if (lives !== 3'(exp_lives)) begin errors++; $display("FAIL miss_lives got %0d want %0d", lives, exp_lives); end
      checks++; if (move_en !== 1'b0) begin errors++; $display("FAIL miss_move_en got %0b want 0", move_en); end
      checks++; if (ball_rst !== 1'b0) begin errors++; $display("FAIL miss_ball_rst got %0b want 0", ball_rst); end
      safe_inputs();
      for (int i = 0; i < MISS_FRAMES; i++) begin
         int gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            brick_hit = $urandom_range(0, 1);
            tick();
            checks++; if (state !== 3'd3 || move_en !== 1'b0) begin errors++; $display("FAIL miss_hold state %0d move_en %0b want 3/0", state, move_en); end
         end
         brick_hit = 1'b0;
         start = (i == MISS_FRAMES - 1) ? start_on_exit : 1'b0;
         pulse_frame();
      end
      if (exp_lives == 0) begin
         checks++; if (state !== 3'd4) begin errors++; $display("FAIL miss_to_over state got %0d want 4", state); end
         checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL miss_to_over game_over got %0b want 1", game_over); end
      end else begin
         checks++; if (state !== 3'd1) begin errors++; $display("FAIL miss_to_serve state got %0d want 1", state); end
         checks++; if (ball_rst !== 1'b1) begin errors++; $display("FAIL miss_to_serve ball_rst got %0b want 1", ball_rst); end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; frame_tick = 1'b0; brick_hit = 1'b0;
      safe_inputs();
      tick();
      tick();
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
      checks++; if (lives !== 3'(LIVES)) begin errors++; $display("FAIL reset_lives got %0d want %0d", lives, LIVES); end
      checks++; if (ball_rst !== 1'b1) begin errors++; $display("FAIL reset_ball_rst got %0b want 1", ball_rst); end
      checks++; if (move_en !== 1'b0) begin errors++; $display("FAIL reset_move_en got %0b want 0", move_en); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got %0b want 0", game_over); end
      checks++; if (win !== 1'b0) begin errors++; $display("FAIL reset_win got %0b want 0", win); end
      reset = 1'b0;
      exp_lives = LIVES;
   endtask

   task automatic test_serve();
      for (int c = 0; c < 2; c++) begin
         frame_tick = $urandom_range(0, 1);
         tick();
         checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_hold state got %0d want 0", state); end
      end
      frame_tick = 1'b0;
      start = 1'b1;
      tick();
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL idle_start state got %0d want 1", state); end
      serve_to_play(1'($urandom_range(0, 1)));
   endtask

   task automatic test_play_steps();
      run_play(20);
   endtask

   task automatic test_miss();
      run_play($urandom_range(1, 10));
      do_miss(1'b0);
      serve_to_play(1'b0);
   endtask

   task automatic test_game_over();
      while (exp_lives > 0) begin
         run_play($urandom_range(1, 12));
         do_miss(exp_lives == 1);
         if (exp_lives > 0) serve_to_play(1'($urandom_range(0, 1)));
      end
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (state !== 3'd4 || game_over !== 1'b1 || lives !== 3'd0) begin errors++; $display("FAIL over_hold state %0d go %0b lives %0d want 4/1/0", state, game_over, lives); end
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_lives = LIVES;
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL over_restart state got %0d want 1", state); end
      checks++; if (lives !== 3'(LIVES)) begin errors++; $display("FAIL over_restart lives got %0d want %0d", lives, LIVES); end
      checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL over_restart game_over got %0b want 0", game_over); end
      serve_to_play(1'b0);
   endtask

   task automatic test_win();
      run_play($urandom_range(1, 10));
      do_miss(1'b0);
      serve_to_play(1'b0);
      run_play($urandom_range(1, 6));
      bricks_left = 6'd0;
      ball_y      = 9'd480;
      tick();
      safe_inputs();
      checks++; if (state !== 3'd5) begin errors++; $display("FAIL win_state got %0d want 5", state); end
      checks++; if (win !== 1'b1) begin errors++; $display("FAIL win_flag got %0b want 1", win); end
      checks++; if (lives !== 3'(exp_lives)) begin errors++; $display("FAIL win_lives got %0d want %0d", lives, exp_lives); end
      checks++; if (ball_rst !== 1'b1 || move_en !== 1'b0) begin errors++; $display("FAIL win_ball ball_rst %0b move_en %0b want 1/0", ball_rst, move_en); end
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_lives = LIVES;
      checks++; if (state !== 3'd1 || win !== 1'b0) begin errors++; $display("FAIL win_restart state %0d win %0b want 1/0", state, win); end
      checks++; if (lives !== 3'(LIVES)) begin errors++; $display("FAIL win_restart lives got %0d want %0d", lives, LIVES); end
      serve_to_play(1'b0);
   endtask

   task automatic test_reset_mid();
      run_play($urandom_range(1, 5));
      do_miss(1'b0);
      serve_to_play(1'b0);
      run_play(STEP_DIV - 1 + STEP_DIV * $urandom_range(0, 2));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_lives = LIVES;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL midreset_state got %0d want 0", state); end
      checks++; if (move_en !== 1'b0) begin errors++; $display("FAIL midreset_move_en got %0b want 0", move_en); end
      checks++; if (lives !== 3'(LIVES)) begin errors++; $display("FAIL midreset_lives got %0d want %0d", lives, LIVES); end
      checks++; if (ball_rst !== 1'b1) begin errors++; $display("FAIL midreset_ball_rst got %0b want 1", ball_rst); end
   endtask

   initial begin
      test_reset();
      test_serve();
      test_play_steps();
      test_miss();
      test_game_over();
      test_win();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
